// File: rtl/mux_rr_arbiter_if.sv
// mux_rr_arbiter_if: request/data inputs and handshake outputs of the round-robin mux arbiter
interface mux_rr_arbiter_if #(parameter int SIZE = 4, parameter int N = 3);
  logic [(1<<N)-1:0]      req;
  logic [SIZE*(1<<N)-1:0] in;
  logic                   out_ready;
  logic                   out_valid;
  logic [SIZE-1:0]        out_data;
  logic [N-1:0]           out_sel;
  logic [(1<<N)-1:0]      ack;
  modport master (input req, in, out_ready, output out_valid, out_data, out_sel, ack);
  modport slave (output req, in, out_ready, input out_valid, out_data, out_sel, ack);
endinterface

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin arbiter sharing one SIZE-bit mux path among 2**N requesters
module mux_rr_arbiter #(
  parameter int SIZE = 4,
  parameter int N    = 3
) (
  input logic               clk,
  input logic               rst,
  mux_rr_arbiter_if.master  bus
);
  localparam int R = 1 << N;
  typedef enum logic {IDLE, HOLD} state_t;
  state_t          state_q;
  logic [N-1:0]    ptr_q, sel_q, start, win_d, idx;
  logic [SIZE-1:0] data_q;
  logic            valid_q, accept, any;
  assign accept = valid_q & bus.out_ready;
  assign any    = |bus.req;
  // On accept the search restarts just past the winner being retired.
  assign start  = (state_q == HOLD) ? sel_q + 1'b1 : ptr_q;
  always_comb begin
    win_d = start;
    idx   = start;
    for (int k = R - 1; k >= 0; k--) begin
      idx = start + N'(k);
      win_d = bus.req[idx] ? idx : win_d;
    end
  end
  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.out_sel   = sel_q;
  assign bus.ack       = accept ? (R)'(1) << sel_q : '0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (state_q == IDLE ? any : accept) begin
      if (state_q == HOLD) ptr_q <= sel_q + 1'b1;
      if (any) begin
        state_q <= HOLD;
        valid_q <= 1'b1;
        sel_q   <= win_d;
        data_q  <= bus.in[SIZE*win_d +: SIZE];
      end else begin
        state_q <= IDLE;
        valid_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb_mux_rr_arbiter: directed spec cases plus randomized traffic against a queue-free round-robin model
module tb_mux_rr_arbiter;
  localparam int SIZE = 4;
  localparam int N    = 3;
  localparam int R    = 1 << N;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  mux_rr_arbiter_if #(.SIZE(SIZE), .N(N)) bus();
  mux_rr_arbiter #(.SIZE(SIZE), .N(N)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  logic            m_valid = 1'b0;
  int              m_sel = 0;
  int              m_ptr = 0;
  logic [SIZE-1:0] m_data = '0;
  int              w, s;
  function automatic int pick(input logic [R-1:0] r, input int st);
    for (int k = 0; k < R; k++) if (r[(st + k) % R]) return (st + k) % R;
    return -1;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask
  task automatic lit(input string nm, input logic v, input int sel, input int d, input logic [R-1:0] a);
    chk({nm, ".valid"}, 32'(bus.out_valid), 32'(v));
    if (v) chk({nm, ".sel"}, 32'(bus.out_sel), 32'(sel));
    if (v) chk({nm, ".data"}, 32'(bus.out_data), 32'(d));
    chk({nm, ".ack"}, 32'(bus.ack), 32'(a));
  endtask
  task automatic drv(input logic [R-1:0] r, input logic rdy);
    #1;
    bus.req = r;
    bus.out_ready = rdy;
  endtask
  // Model: rotate the search start, pick the first requester, retire on handshake.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_sel   <= 0;
      m_ptr   <= 0;
      m_data  <= '0;
    end else if (!m_valid || bus.out_ready) begin
      s = m_valid ? (m_sel + 1) % R : m_ptr;
      if (m_valid) m_ptr <= s;
      w = pick(bus.req, s);
      if (w >= 0) begin
        m_valid <= 1'b1;
        m_sel   <= w;
        m_data  <= SIZE'(bus.in >> (SIZE * w));
      end else m_valid <= 1'b0;
    end
  end
  always @(negedge clk) if (!rst) begin
    chk("model.valid", 32'(bus.out_valid), 32'(m_valid));
    chk("model.ack", 32'(bus.ack), (m_valid && bus.out_ready) ? 32'(1) << m_sel : 32'(0));
    if (m_valid) chk("model.sel", 32'(bus.out_sel), 32'(m_sel));
    if (m_valid) chk("model.data", 32'(bus.out_data), 32'(m_data));
  end
  initial begin
    bus.req = '0;
    bus.out_ready = 1'b0;
    bus.in = 32'h76543210;
    @(negedge clk);
    lit("reset", 1'b0, 0, 0, 8'h00);
    #1 rst = 1'b0;
    drv(8'hFF, 1'b1);
    for (int k = 0; k <= R; k++) begin
      @(negedge clk);
      lit("all_req", 1'b1, k % R, k % R, 8'(1 << (k % R)));
    end
    drv(8'h00, 1'b1);
    @(negedge clk);
    lit("all_idle", 1'b0, 0, 0, 8'h00);
    drv(8'h08, 1'b1);
    @(negedge clk);
    lit("single", 1'b1, 3, 3, 8'h08);
    drv(8'h00, 1'b1);
    @(negedge clk);
    lit("single_idle", 1'b0, 0, 0, 8'h00);
    drv(8'h05, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      lit("bp_hold", 1'b1, 0, 0, 8'h00);
    end
    drv(8'h05, 1'b1);
    #1 lit("bp_accept", 1'b1, 0, 0, 8'h01);
    @(negedge clk);
    lit("bp_next", 1'b1, 2, 2, 8'h04);
    drv(8'h00, 1'b1);
    @(negedge clk);
    drv(8'h80, 1'b1);
    @(negedge clk);
    lit("wrap7", 1'b1, 7, 7, 8'h80);
    drv(8'h81, 1'b1);
    @(negedge clk);
    lit("wrap0", 1'b1, 0, 0, 8'h01);
    @(negedge clk);
    lit("wrap7b", 1'b1, 7, 7, 8'h80);
    drv(8'h00, 1'b1);
    @(negedge clk);
    drv(8'h20, 1'b0);
    @(negedge clk);
    lit("hold5", 1'b1, 5, 5, 8'h00);
    #2 rst = 1'b1;
    #1 chk("rst_async.valid", 32'(bus.out_valid), 32'd0);
    chk("rst_async.sel", 32'(bus.out_sel), 32'd0);
    chk("rst_async.data", 32'(bus.out_data), 32'd0);
    chk("rst_async.ack", 32'(bus.ack), 32'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    bus.req = 8'hA0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    lit("post_rst5", 1'b1, 5, 5, 8'h20);
    @(negedge clk);
    lit("post_rst7", 1'b1, 7, 7, 8'h80);
    drv(8'h00, 1'b1);
    @(negedge clk);
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      #1;
      bus.req = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) bus.in = $urandom;
      if ($urandom_range(0, 199) == 0) begin
        #1 rst = 1'b1;
        #1 chk("rnd_rst.valid", 32'(bus.out_valid), 32'd0);
        #1 rst = 1'b0;
      end
    end
    drv(8'h00, 1'b1);
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
